// File: rtl/addsub_pipe_pkg.sv
// Shared types for the chunked add/subtract pipeline.
package addsub_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mode_e;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic borrow;
    logic zero;
    logic err;
  } flags_t;

endpackage

// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe.
interface addsub_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             borrow;
  logic             zero;
  logic             err;

  modport master (
    output in_valid, a, b, sub, signed_mode, out_ready,
    input  in_ready, out_valid, result, carry, overflow, borrow, zero, err
  );

  modport slave (
    input  in_valid, a, b, sub, signed_mode, out_ready,
    output in_ready, out_valid, result, carry, overflow, borrow, zero, err
  );
endinterface

// File: rtl/addsub_pipe_chunk.sv
// One CHUNK-bit ripple-carry adder slice; also exposes the carry into its top bit.
module addsub_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             ctop_o
);
  logic [CHUNK:0] c;

  // Bit-serial carry ripple across the slice.
  always_comb begin
    c    = '0;
    c[0] = cin_i;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      c[i+1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    sum_o  = a_i ^ b_i ^ c[CHUNK-1:0];
    cout_o = c[CHUNK];
    ctop_o = c[CHUNK-1];
  end
endmodule

// File: rtl/addsub_pipe.sv
// Pipelined adder/subtractor: one CHUNK-bit slice per stage, whole-pipe stall.
// Optional result saturation is enabled by defining ADDSUB_PIPE_SAT_EN.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic          clk,
  input logic          rst_n,
  addsub_pipe_if.slave bus
);
  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned LAST   = STAGES - 1;

  // Stage registers: operands travel whole, sum fills in one chunk per stage.
  logic             v_q    [STAGES];
  logic [WIDTH-1:0] a_q    [STAGES];
  logic [WIDTH-1:0] bx_q   [STAGES];
  logic [WIDTH-1:0] sum_q  [STAGES];
  logic             c_q    [STAGES];
  logic             ctop_q [STAGES];
  mode_e            mode_q [STAGES];
  logic             sgn_q  [STAGES];

  // Inputs seen by each stage (interface for stage 0, previous register otherwise).
  logic             v_p    [STAGES];
  logic [WIDTH-1:0] a_p    [STAGES];
  logic [WIDTH-1:0] bx_p   [STAGES];
  logic [WIDTH-1:0] sum_p  [STAGES];
  logic             cin_p  [STAGES];
  mode_e            mode_p [STAGES];
  logic             sgn_p  [STAGES];

  logic [WIDTH-1:0] sum_d  [STAGES];
  logic             c_d    [STAGES];
  logic             ctop_d [STAGES];

  logic             advance;
  flags_t           flags;
  logic [WIDTH-1:0] res;

  assign advance = !v_q[LAST] || bus.out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] csum;

    if (k == 0) begin : g_head
      assign v_p[k]    = bus.in_valid;
      assign a_p[k]    = bus.a;
      assign bx_p[k]   = bus.b ^ {WIDTH{bus.sub}};
      assign sum_p[k]  = '0;
      assign cin_p[k]  = bus.sub;
      assign mode_p[k] = mode_e'(bus.sub);
      assign sgn_p[k]  = bus.signed_mode;
    end else begin : g_body
      assign v_p[k]    = v_q[k-1];
      assign a_p[k]    = a_q[k-1];
      assign bx_p[k]   = bx_q[k-1];
      assign sum_p[k]  = sum_q[k-1];
      assign cin_p[k]  = c_q[k-1];
      assign mode_p[k] = mode_q[k-1];
      assign sgn_p[k]  = sgn_q[k-1];
    end

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a_i   (a_p[k][k*CHUNK +: CHUNK]),
      .b_i   (bx_p[k][k*CHUNK +: CHUNK]),
      .cin_i (cin_p[k]),
      .sum_o (csum),
      .cout_o(c_d[k]),
      .ctop_o(ctop_d[k])
    );

    // Splice this stage's chunk into the partial sum carried by the token.
    assign sum_d[k] = (sum_p[k] & ~(WIDTH'({CHUNK{1'b1}}) << (k*CHUNK)))
                    | (WIDTH'(csum) << (k*CHUNK));
  end

  // Stage registers advance together; reset drops every in-flight token.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        v_q[i]    <= 1'b0;
        a_q[i]    <= '0;
        bx_q[i]   <= '0;
        sum_q[i]  <= '0;
        c_q[i]    <= 1'b0;
        ctop_q[i] <= 1'b0;
        mode_q[i] <= ADD;
        sgn_q[i]  <= 1'b0;
      end
    end else if (advance) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        v_q[i]    <= v_p[i];
        a_q[i]    <= a_p[i];
        bx_q[i]   <= bx_p[i];
        sum_q[i]  <= sum_d[i];
        c_q[i]    <= c_d[i];
        ctop_q[i] <= ctop_d[i];
        mode_q[i] <= mode_p[i];
        sgn_q[i]  <= sgn_p[i];
      end
    end
  end

  // Flags and (optionally saturated) result from the final stage; zeroed when idle.
  always_comb begin
    flags          = '0;
    flags.carry    = c_q[LAST];
    flags.overflow = sgn_q[LAST] & (ctop_q[LAST] ^ c_q[LAST]);
    flags.borrow   = (mode_q[LAST] == SUB) & ~sgn_q[LAST] & ~c_q[LAST];
    flags.err      = flags.overflow | flags.borrow;
    res            = sum_q[LAST];
`ifdef ADDSUB_PIPE_SAT_EN
    if (flags.overflow) begin
      res = a_q[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else if (flags.borrow) begin
      res = '0;
    end
`else
`endif
    flags.zero = (res == '0);
    if (!v_q[LAST]) begin
      res   = '0;
      flags = '0;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = v_q[LAST];
  assign bus.result    = res;
  assign bus.carry     = flags.carry;
  assign bus.overflow  = flags.overflow;
  assign bus.borrow    = flags.borrow;
  assign bus.zero      = flags.zero;
  assign bus.err       = flags.err;
endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=32, CHUNK=8, latency 4).
module tb_addsub_pipe;
  localparam int W = 32;
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        o;
    logic        b;
    logic        z;
    logic        e;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  addsub_pipe_if #(.WIDTH(W)) bif ();
  addsub_pipe #(.WIDTH(W), .CHUNK(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  obs_t exp_q[$];
  int   vecs = 0;
  int   errs = 0;

  // Reference: plain integer arithmetic on the operands.
  function automatic obs_t model(logic [31:0] a, logic [31:0] b, logic sub, logic sgn);
    obs_t        m;
    longint      sf;
    logic [32:0] s33;
    sf   = sub ? (longint'($signed(a)) - longint'($signed(b)))
               : (longint'($signed(a)) + longint'($signed(b)));
    s33  = {1'b0, a} + {1'b0, b};
    m.r  = sub ? a - b : a + b;
    m.c  = sub ? (a >= b) : s33[32];
    m.o  = sgn && (sf > SMAX || sf < SMIN);
    m.b  = sub && !sgn && (a < b);
    m.e  = m.o || m.b;
`ifdef ADDSUB_PIPE_SAT_EN
    if (m.o) m.r = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else if (m.b) m.r = 32'h0;
`endif
    m.z  = (m.r == 32'h0);
    return m;
  endfunction

  function automatic obs_t observe();
    return {bif.result, bif.carry, bif.overflow, bif.borrow, bif.zero, bif.err};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.in_valid    = 1'b0;
    bif.a           = '0;
    bif.b           = '0;
    bif.sub         = 1'b0;
    bif.signed_mode = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bif.out_ready = 1'b1;
    cyc();
    cyc();
    vecs++;
    if (observe() !== '0 || bif.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_outputs: got valid=%b %h, expected valid=0 %h", bif.out_valid, observe(), obs_t'(0));
    end
    vecs++;
    if (bif.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_in_ready: got %b expected 1", bif.in_ready);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  // Single token, measure latency and compare value/flags.
  task automatic one_token(string name, logic [31:0] a, logic [31:0] b, logic sub, logic sgn);
    int   lat;
    obs_t exp;
    exp = model(a, b, sub, sgn);
    bif.out_ready = 1'b1;
    bif.a = a; bif.b = b; bif.sub = sub; bif.signed_mode = sgn;
    bif.in_valid = 1'b1;
    #1;
    vecs++;
    if (bif.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL %s_in_ready: got %b expected 1", name, bif.in_ready);
    end
    cyc();
    lat = 1;
    idle_inputs();
    while (bif.out_valid !== 1'b1 && lat < 20) begin
      cyc();
      lat++;
    end
    vecs++;
    if (lat != 4) begin
      errs++;
      $display("FAIL %s_latency: got %0d expected 4", name, lat);
    end
    vecs++;
    if (observe() !== exp) begin
      errs++;
      $display("FAIL %s_value: got %h expected %h", name, observe(), exp);
    end
    cyc();
  endtask

  task automatic test_directed();
    one_token("add_ff_1",      32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    one_token("sadd_ovf",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    one_token("usub_borrow",   32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0);
    one_token("usub_zero",     32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0);
    one_token("uadd_wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    one_token("ssub_ovf_neg",  32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta[6], tb[6];
    logic        ts[6], tg[6];
    int   sent = 0, got = 0, cycle = 0;
    logic held_v = 1'b0;
    obs_t held = '0;
    obs_t exp;
    for (int i = 0; i < 6; i++) begin
      ta[i] = pick(); tb[i] = pick();
      ts[i] = 1'(($urandom) & 1); tg[i] = 1'(($urandom) & 1);
    end
    while (got < 6 && cycle < 60) begin
      bif.out_ready = !(cycle >= 5 && cycle <= 7);
      if (sent < 6) begin
        bif.in_valid = 1'b1;
        bif.a = ta[sent]; bif.b = tb[sent]; bif.sub = ts[sent]; bif.signed_mode = tg[sent];
      end else begin
        idle_inputs();
      end
      #1;
      if (held_v) begin
        vecs++;
        if (observe() !== held || bif.out_valid !== 1'b1) begin
          errs++;
          $display("FAIL b2b_stall_hold: got valid=%b %h expected valid=1 %h", bif.out_valid, observe(), held);
        end
      end
      held_v = bif.out_valid && !bif.out_ready;
      held   = observe();
      if (bif.out_valid && bif.out_ready) begin
        vecs++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL b2b_extra_output: got %h expected none", observe());
        end else begin
          exp = exp_q.pop_front();
          if (observe() !== exp) begin
            errs++;
            $display("FAIL b2b_value: got %h expected %h", observe(), exp);
          end
        end
        got++;
      end
      if (bif.in_valid && bif.in_ready) begin
        exp_q.push_back(model(bif.a, bif.b, bif.sub, bif.signed_mode));
        sent++;
      end
      cyc();
      cycle++;
    end
    idle_inputs();
    vecs++;
    if (got != 6 || exp_q.size() != 0) begin
      errs++;
      $display("FAIL b2b_count: got %0d outputs (%0d pending) expected 6 (0 pending)", got, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_random(int n);
    int   sent = 0, got = 0, guard = 0;
    obs_t exp;
    while (got < n && guard < n * 10) begin
      bif.out_ready = ($urandom_range(0, 3) != 0);
      if (sent < n && $urandom_range(0, 3) != 0) begin
        bif.in_valid = 1'b1;
        bif.a = pick(); bif.b = pick();
        bif.sub = 1'(($urandom) & 1); bif.signed_mode = 1'(($urandom) & 1);
      end else begin
        idle_inputs();
      end
      #1;
      if (bif.out_valid && bif.out_ready) begin
        vecs++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL rand_extra_output: got %h expected none", observe());
        end else begin
          exp = exp_q.pop_front();
          if (observe() !== exp) begin
            errs++;
            $display("FAIL rand_value: got %h expected %h", observe(), exp);
          end
        end
        got++;
      end
      if (bif.in_valid && bif.in_ready) begin
        exp_q.push_back(model(bif.a, bif.b, bif.sub, bif.signed_mode));
        sent++;
      end
      cyc();
      guard++;
    end
    idle_inputs();
    vecs++;
    if (got != n || exp_q.size() != 0) begin
      errs++;
      $display("FAIL rand_count: got %0d outputs (%0d pending) expected %0d (0 pending)", got, exp_q.size(), n);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_flight();
    logic stale = 1'b0;
    bif.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bif.in_valid = 1'b1;
      bif.a = pick(); bif.b = pick(); bif.sub = 1'b0; bif.signed_mode = 1'b0;
      cyc();
    end
    idle_inputs();
    rst_n = 1'b0;
    cyc();
    vecs++;
    if (bif.out_valid !== 1'b0 || observe() !== '0) begin
      errs++;
      $display("FAIL flight_reset_clear: got valid=%b %h expected valid=0 %h", bif.out_valid, observe(), obs_t'(0));
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (bif.out_valid === 1'b1) stale = 1'b1;
    end
    vecs++;
    if (stale !== 1'b0) begin
      errs++;
      $display("FAIL flight_stale_output: got stale=%b expected 0", stale);
    end
    one_token("post_reset", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    bif.out_ready = 1'b1;
    idle_inputs();
    test_reset();
    test_directed();
    test_back_to_back();
    test_random(300);
    test_reset_flight();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits added per pipeline stage; WIDTH % CHUNK == 0 and CHUNK >= 2.
REQ-003 SHALL have one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  operand set offered.
REQ-007 in_ready  output  1  stage 0 can accept.
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 sub  input  1  1 = a - b, 0 = a + b.
REQ-010 signed_mode  input  1  1 = two's-complement flag interpretation.
REQ-011 out_valid  output  1  result and flags valid.
REQ-012 out_ready  input  1  consumer accepts.
REQ-013 result  output  WIDTH  sum/difference.
REQ-014 carry, overflow, borrow, zero, err  output  1 each  status flags.

Function
REQ-015 SHALL compute a + (b XOR {WIDTH{sub}}) + sub in STAGES = WIDTH/CHUNK ripple stages, chunk k added in stage k.
REQ-016 SHALL register chunk carry-out between stages; unprocessed operand chunks and finished result chunks travel with the token.
REQ-017 Latency SHALL be exactly STAGES cycles from accepted input (in_valid && in_ready) to out_valid, absent stalls.
REQ-018 Throughput SHALL be one operation per cycle when out_ready is held high.
REQ-019 Pipeline SHALL stall as a whole: advance = !out_valid || out_ready; in_ready = advance.
REQ-020 While out_valid && !out_ready, result and all flags SHALL hold stable.
REQ-021 Bubbles SHALL propagate as cleared stage-valid bits; data of invalid stages is don't-care.
REQ-022 carry SHALL equal the carry out of bit WIDTH-1.
REQ-023 overflow SHALL equal signed_mode AND (carry into MSB XOR carry out of MSB); 0 when signed_mode = 0.
REQ-024 borrow SHALL equal sub AND NOT signed_mode AND NOT carry (unsigned a < b).
REQ-025 zero SHALL be 1 when the presented result equals 0.
REQ-026 err SHALL equal overflow OR borrow.
REQ-027 sub and signed_mode SHALL be captured with operands and apply to that token only; changes mid-stream affect no in-flight token.
REQ-028 Unsigned add carry-out SHALL wrap silently (carry = 1, err = 0).

Reset
REQ-029 On rst_n = 0 at a clock edge: all stage-valid bits, out_valid, result, and all flags SHALL become 0; in_ready SHALL be 1 in the cycle after.
REQ-030 Reset mid-operation SHALL discard all in-flight tokens; none appear after reset release.

Configuration
REQ-031 With ADDSUB_PIPE_SAT_EN defined, result SHALL saturate: signed overflow -> max positive (a non-negative) or min negative (a negative); unsigned borrow -> 0; flags still report the raw condition.
REQ-032 Without ADDSUB_PIPE_SAT_EN, result SHALL be the wrapped modulo-2^WIDTH value and no saturation logic exists.
REQ-033 zero SHALL reflect the final presented result (post-saturation when enabled).

Structure
REQ-034 Package addsub_pkg SHALL hold the flags struct typedef (carry, overflow, borrow, zero, err) and a mode enum {ADD, SUB}.
REQ-035 Sub-module addsub_chunk SHALL implement one CHUNK-bit ripple adder (a, b, cin -> sum, cout, carry into top bit), instantiated STAGES times by generate.

Verification (WIDTH=32, CHUNK=8, latency 4)
REQ-036 Add 0x0000_00FF + 0x0000_0001, unsigned -> result 0x0000_0100, all flags 0, out_valid 4 cycles after acceptance.
REQ-037 Signed add 0x7FFF_FFFF + 1 -> overflow=1, err=1, result 0x8000_0000 (0x7FFF_FFFF with SAT_EN).
REQ-038 Unsigned sub 3 - 5 -> borrow=1, carry=0, result 0xFFFF_FFFE (0 with SAT_EN); unsigned sub 5 - 5 -> zero=1, carry=1, borrow=0.
REQ-039 Back-to-back 6 tokens with out_ready low for 3 cycles mid-burst -> all 6 results in order, none lost or duplicated, outputs stable during stall.
REQ-040 Reset asserted with 3 tokens in flight -> out_valid=0 next cycle, no stale result after release; first new token emerges at latency 4.
